// File: rtl/fixed_point_arith_pkg.sv
// Shared definitions for the FixedPointArithmetic IP: FSM state encoding and
// chunking helpers used to split an N-bit datapath into W-bit slices.
package fixed_point_arith_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_BUSY = BUSY,
    ST_DONE = DONE
  } state_e;

  // Number of W-bit chunk cycles needed for one N-bit operation.
  function automatic int chunk_count(input int n, input int w);
    return (w == 0) ? 0 : n / w;
  endfunction

  function automatic bit chunk_cfg_ok(input int n, input int w);
    return (w >= 1) && (w <= n) && ((n % w) == 0);
  endfunction

endpackage

// File: rtl/chunk_ripple_add.sv
// Combinational W-bit ripple-carry slice; also reports the carry into its MSB
// so the top can form two's-complement overflow on the final chunk.
module chunk_ripple_add #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         cmsb
);

  always_comb begin : ripple
    logic cy;
    cy   = cin;
    cmsb = cin;
    sum  = '0;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) cmsb = cy;
      sum[i] = a[i] ^ b[i] ^ cy;
      cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
    end
    cout = cy;
  end

endmodule

// File: rtl/chunked_add_seq.sv
// Multi-cycle N-bit adder/subtractor: one W-bit chunk per clock through a
// registered carry, with valid/ready handshakes on both sides.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; in_ready is high only in IDLE, out_valid only in DONE, and results stay
// stable in DONE until out_ready is seen.
module chunked_add_seq
  import fixed_point_arith_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         co,
  output logic         ov
);

  localparam int K  = chunk_count(N, W);
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  if (!chunk_cfg_ok(N, W)) begin : g_cfg_check
    $error("chunked_add_seq: N must be a multiple of W and 1 <= W <= N");
  end

  state_e        state;
  logic [N-1:0]  a_r;
  logic [N-1:0]  b_r;
  logic [N-1:0]  c_r;
  logic          carry;
  logic [IW-1:0] idx;
  logic          co_r;
  logic          ov_r;

  logic [W-1:0]  a_chunk;
  logic [W-1:0]  b_chunk;
  logic [W-1:0]  sum;
  logic          cout;
  logic          cmsb;
  logic          last;

  assign a_chunk = a_r[idx*W +: W];
  assign b_chunk = b_r[idx*W +: W];
  assign last    = (idx == IW'(K - 1));

  chunk_ripple_add #(.W(W)) u_slice (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (carry),
    .sum  (sum),
    .cout (cout),
    .cmsb (cmsb)
  );

  // b is stored already inverted for subtract, so BUSY only ever adds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      a_r   <= '0;
      b_r   <= '0;
      c_r   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      co_r  <= 1'b0;
      ov_r  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b ^ {N{sub}};
            carry <= ci ^ sub;
            idx   <= '0;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          c_r[idx*W +: W] <= sum;
          carry           <= cout;
          if (last) begin
            co_r  <= cout;
            ov_r  <= cout ^ cmsb;
            idx   <= '0;
            state <= ST_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign c         = c_r;
  assign co        = co_r;
  assign ov        = ov_r;

endmodule

// File: tb/tb_chunked_add_seq.sv
// Bench for chunked_add_seq: three configurations (32/8, 16/16, 12/3), directed
// corner cases on the 32/8 instance, then concurrent randomized traffic.
module tb_chunked_add_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  in_valid, ci, sub, out_ready;
  logic [31:0] a[3];
  logic [31:0] b[3];
  wire  [2:0]  in_ready, out_valid, co, ov;
  wire  [31:0] c0;
  wire  [15:0] c1;
  wire  [11:0] c2;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  logic rand_on;

  // Expected {co, ov, c} per lane, and accept edge numbers for latency.
  logic [33:0] exp_q[3][$];
  int          acc_q[3][$];

  always @(posedge clk) cyc <= cyc + 1;

  chunked_add_seq #(.N(32), .W(8)) u_n32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a[0]), .b(b[0]), .ci(ci[0]), .sub(sub[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .c(c0), .co(co[0]), .ov(ov[0]));

  chunked_add_seq #(.N(16), .W(16)) u_n16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a[1][15:0]), .b(b[1][15:0]), .ci(ci[1]), .sub(sub[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .c(c1), .co(co[1]), .ov(ov[1]));

  chunked_add_seq #(.N(12), .W(3)) u_n12 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a[2][11:0]), .b(b[2][11:0]), .ci(ci[2]), .sub(sub[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .c(c2), .co(co[2]), .ov(ov[2]));

  function automatic int n_of(input int l);
    case (l)
      0:       return 32;
      1:       return 16;
      default: return 12;
    endcase
  endfunction

  function automatic int k_of(input int l);
    case (l)
      0:       return 4;
      1:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] c_of(input int l);
    case (l)
      0:       return c0;
      1:       return {16'd0, c1};
      default: return {20'd0, c2};
    endcase
  endfunction

  function automatic logic [31:0] mask_of(input int n);
    return (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
  endfunction

  // Reference: plain integer arithmetic; overflow from operand/result signs.
  function automatic logic [33:0] ref_model(input int n, input logic [31:0] av,
                                            input logic [31:0] bv, input logic civ,
                                            input logic subv);
    logic [63:0] m, aa, bb, s;
    logic        co_e, ov_e;
    m    = (64'd1 << n) - 64'd1;
    aa   = {32'd0, av} & m;
    bb   = (subv ? ~{32'd0, bv} : {32'd0, bv}) & m;
    s    = aa + bb + {63'd0, civ ^ subv};
    co_e = s[n];
    ov_e = (aa[n-1] == bb[n-1]) && (s[n-1] != aa[n-1]);
    return {co_e, ov_e, s[31:0] & m[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [2:0]  prev;
    logic [33:0] e;
    int          acc;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = '0;
      end else begin
        for (int l = 0; l < 3; l++) begin
          if (out_valid[l] && !prev[l]) begin
            if (acc_q[l].size() == 0) begin
              chk($sformatf("unexpected_valid_lane%0d", l), 64'(out_valid[l]), 64'd0);
            end else begin
              acc = acc_q[l].pop_front();
              chk($sformatf("latency_lane%0d", l), 64'(cyc - acc), 64'(k_of(l)));
            end
          end
          if (out_valid[l] && out_ready[l] && exp_q[l].size() != 0) begin
            e = exp_q[l].pop_front();
            chk($sformatf("result_lane%0d", l), 64'({co[l], ov[l], c_of(l)}), 64'(e));
          end
        end
        prev = out_valid;
      end
    end
  endtask

  // Called just after a rising edge; returns just after the accept edge.
  task automatic issue(input int l, input logic [31:0] av, input logic [31:0] bv,
                       input logic civ, input logic subv, input logic [33:0] expv);
    int t;
    a[l] = av; b[l] = bv; ci[l] = civ; sub[l] = subv; in_valid[l] = 1'b1;
    for (t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready[l] && rst_n) break;
      @(posedge clk); #1;
    end
    if (t == 100) begin
      chk($sformatf("accept_timeout_lane%0d", l), 64'(in_ready[l]), 64'd1);
    end else begin
      exp_q[l].push_back(expv);
      acc_q[l].push_back(cyc + 1);
    end
    @(posedge clk); #1;
    in_valid[l] = 1'b0;
  endtask

  task automatic drain(input int l, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q[l].size() == 0) break;
      @(posedge clk); #1;
    end
    chk($sformatf("drain_lane%0d", l), 64'(exp_q[l].size()), 64'd0);
  endtask

  task automatic rand_lane(input int l, input int nops);
    int          n;
    logic [31:0] m, av, bv;
    logic        civ, subv;
    n = n_of(l);
    m = mask_of(n);
    for (int i = 0; i < nops; i++) begin
      av = $urandom; bv = $urandom;
      case ($urandom_range(0, 5))
        0: av = 32'hFFFF_FFFF;
        1: av = 32'd1 << (n - 1);
        2: av = (32'd1 << (n - 1)) - 32'd1;
        default: ;
      endcase
      case ($urandom_range(0, 5))
        0: bv = 32'hFFFF_FFFF;
        1: bv = 32'd1;
        2: bv = 32'd0;
        default: ;
      endcase
      av   = av & m;
      bv   = bv & m;
      civ  = 1'($urandom_range(0, 1));
      subv = 1'($urandom_range(0, 1));
      issue(l, av, bv, civ, subv, ref_model(n, av, bv, civ, subv));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = '0; ci = '0; sub = '0; out_ready = 3'b111; rand_on = 1'b0;
    for (int l = 0; l < 3; l++) begin a[l] = '0; b[l] = '0; end
    fork
      monitor();
      forever begin
        @(posedge clk); #1;
        if (rand_on) for (int l = 0; l < 3; l++) out_ready[l] = ($urandom_range(0, 2) != 0);
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int l = 0; l < 3; l++) begin
      chk($sformatf("rst_out_valid_lane%0d", l), 64'(out_valid[l]), 64'd0);
      chk($sformatf("rst_c_lane%0d", l), 64'(c_of(l)), 64'd0);
      chk($sformatf("rst_flags_lane%0d", l), 64'({co[l], ov[l]}), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd7);
    @(posedge clk); #1;

    // Directed arithmetic on the 32/8 instance
    issue(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b0, 32'h0000_0100}); drain(0, 50);
    issue(0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, {1'b1, 1'b0, 32'h0000_0000}); drain(0, 50);
    issue(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h8000_0000}); drain(0, 50);
    issue(0, 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE}); drain(0, 50);
    issue(0, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF}); drain(0, 50);
    issue(0, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFD}); drain(0, 50);

    // Backpressure: result held, extra requests ignored
    out_ready[0] = 1'b0;
    issue(0, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0, {1'b0, 1'b0, 32'h2143_6587});
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (out_valid[0]) break;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin a[0] = 32'hFFFF_FFFF; b[0] = 32'hFFFF_FFFF; in_valid[0] = 1'b1; end
      if (i == 5) in_valid[0] = 1'b0;
      @(negedge clk);
      chk("bp_valid", 64'(out_valid[0]), 64'd1);
      chk("bp_c", 64'(c0), 64'h2143_6587);
      chk("bp_flags", 64'({co[0], ov[0]}), 64'd0);
      chk("bp_in_ready", 64'(in_ready[0]), 64'd0);
    end
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    drain(0, 20);

    // Reset two cycles into BUSY discards the partial result
    issue(0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 34'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q[0].delete();
    acc_q[0].delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(out_valid[0]), 64'd0);
    chk("mid_rst_c", 64'(c0), 64'd0);
    chk("mid_rst_flags", 64'({co[0], ov[0]}), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready[0]), 64'd1);
    @(posedge clk); #1;
    issue(0, 32'd3, 32'd4, 1'b0, 1'b0, {1'b0, 1'b0, 32'd7}); drain(0, 50);

    // Randomized back-to-back traffic on all three configurations
    rand_on = 1'b1;
    fork
      rand_lane(0, 40);
      rand_lane(1, 40);
      rand_lane(2, 40);
    join
    rand_on = 1'b0;
    @(posedge clk); #1;
    out_ready = 3'b111;
    for (int l = 0; l < 3; l++) drain(l, 100);
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
